data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the load/store unit and main memory's data port.
- Serves naturally aligned 1/2/4-byte loads and stores.
- Refills whole lines as sequential 4-byte memory reads and writes stores straight through with one memory write.
- Lines are stored in memory byte order. Little-endian conversion to and from the core happens in this block.

Parameters:
- ADDR_WIDTH, 17, byte-address width; matches main memory.
- DATA_LEN, 32, data width.
- BYTE_SIZE, 8, bits per byte.
- LINE_WORD_NUM, 4, 4-byte words per line (power of 2); line = 16 bytes.
- INDEX_WIDTH, 4, index bits; 16 lines.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  cache can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_data_type  in  3  `ONE_BYTE/`TWO_BYTE/`FOUR_BYTE
- req_wdata  in  DATA_LEN  store data, little-endian, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_LEN  load data, zero-extended, little-endian
- resp_error  out  1  valid with resp_valid: misaligned or bad data_type
- d_cache_mem_vis_signal  out  2  `MEM_NOP/`MEM_READ/`MEM_WRITE
- d_cache_mem_vis_addr  out  ADDR_WIDTH  memory address
- mem_written_data  out  DATA_LEN  store data, memory order (byte at addr in [31:24])
- mem_data_type  out  3  store width
- mem_data  in  DATA_LEN  read word, memory order (byte at addr in [31:24])
- mem_status  in  2  `MEM_RESTING/`MEM_INST_FINISHED/`MEM_DATA_FINISHED

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all valid bits cleared; req_ready = 1.
  - resp_valid = 0, resp_error = 0, resp_rdata = 0.
  - d_cache_mem_vis_signal = `MEM_NOP; d_cache_mem_vis_addr = 0; mem_written_data = 0; mem_data_type = 0.
  - Reset mid-refill or mid-write aborts the operation; no response is issued and the line stays invalid.
- Address split:
  - offset = addr[1:0]
  - word = addr[2 +: log2(LINE_WORD_NUM)]
  - index = next INDEX_WIDTH bits
  - tag = remaining upper bits
- All outputs are registered. FSM states: IDLE, LOOKUP, REFILL_WAIT, REFILL_GAP, WRITE_WAIT, WRITE_GAP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request, go to LOOKUP, and drop req_ready until resp_valid.
- LOOKUP:
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] != 0) or unknown data_type: resp_valid = 1, resp_error = 1, no memory access, go to IDLE.
  - Load hit: resp_valid = 1, resp_rdata = selected bytes, go to IDLE. The pulse appears 2 edges after acceptance.
  - Load miss: drive `MEM_READ at line base (word 0), go to REFILL_WAIT.
  - Store (hit or miss): drive `MEM_WRITE with address, mem_data_type and mem_written_data. Go to WRITE_WAIT.
  - Store hit: cached bytes are updated at this edge.
- Byte ordering:
  - Store: mem_written_data[31:24] = wdata[7:0], [23:16] = wdata[15:8], [15:8] = wdata[23:16], [7:0] = wdata[31:24]. Unused bytes = 0.
  - Load: the byte at offset o is word[31-8o -: 8] and is placed at little-endian position.
- REFILL_WAIT:
  - Hold signal and address until mem_status == `MEM_DATA_FINISHED.
  - On that edge: capture mem_data into line word k, drive `MEM_NOP, go to REFILL_GAP.
  - `MEM_INST_FINISHED is ignored.
- REFILL_GAP:
  - Wait until mem_status == `MEM_RESTING; this prevents a stale FINISHED being read as completion of the next request.
  - If k < LINE_WORD_NUM-1: issue `MEM_READ at base + 4(k+1), go to REFILL_WAIT.
  - Otherwise: write tag, set valid, emit the load response from the refilled line, go to IDLE.
- WRITE_WAIT:
  - Hold until `MEM_DATA_FINISHED, then drive `MEM_NOP and go to WRITE_GAP.
- WRITE_GAP:
  - Wait for `MEM_RESTING, then resp_valid = 1, go to IDLE.
- General rules:
  - No write-allocate: a store miss leaves cache state unchanged.
  - Conflicting index with a different tag on refill overwrites the line; write-through means no writeback is needed.
  - resp_valid is exactly one cycle. resp_rdata holds until the next response.
  - Requests are never accepted while busy; req_valid held during busy is ignored until IDLE.

Test Plan:
1. Cold load word: mem bytes 0x10..0x13 = 11 22 33 44, load FOUR_BYTE @0x10 -> 4 `MEM_READ at 0x10, 0x14, 0x18, 0x1C with a `MEM_NOP between each; resp_rdata = 0x44332211, resp_error = 0.
2. Hit after fill: load ONE_BYTE @0x13 -> no memory traffic; resp_valid 2 edges after acceptance; resp_rdata = 0x00000044.
3. Store hit then load: store TWO_BYTE @0x12, wdata = 0xBEEF -> `MEM_WRITE addr 0x12, mem_written_data = 0xEFBE0000, TWO_BYTE. Then load word @0x10 hits -> 0xBEEF2211.
4. Store miss @0x400 word 0xCAFEF00D -> one `MEM_WRITE, data 0x0DF0FECA. Next load @0x400 misses and refills.
5. Misaligned load word @0x11 -> resp_valid with resp_error = 1; d_cache_mem_vis_signal stays `MEM_NOP.
6. Reset during the 2nd refill read -> all outputs at reset values immediately. Repeating the load @0x10 afterwards misses and refills fully.

Source files
------------

// File: rtl/data_cache_if.sv
// data_cache_if: core request/response and memory data-port signals of the data cache
`ifndef ONE_BYTE
`define ONE_BYTE 3'b001
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b010
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b100
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b01
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b10
`endif

interface data_cache_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_LEN   = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_data_type;
    logic [DATA_LEN-1:0]   req_wdata;
    logic                  resp_valid;
    logic [DATA_LEN-1:0]   resp_rdata;
    logic                  resp_error;
    logic [1:0]            d_cache_mem_vis_signal;
    logic [ADDR_WIDTH-1:0] d_cache_mem_vis_addr;
    logic [DATA_LEN-1:0]   mem_written_data;
    logic [2:0]            mem_data_type;
    logic [DATA_LEN-1:0]   mem_data;
    logic [1:0]            mem_status;

    modport slave (
        input  req_valid, req_write, req_addr, req_data_type, req_wdata, mem_data, mem_status,
        output req_ready, resp_valid, resp_rdata, resp_error,
               d_cache_mem_vis_signal, d_cache_mem_vis_addr, mem_written_data, mem_data_type
    );

    modport master (
        output req_valid, req_write, req_addr, req_data_type, req_wdata, mem_data, mem_status,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               d_cache_mem_vis_signal, d_cache_mem_vis_addr, mem_written_data, mem_data_type
    );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with little-endian core view
`ifndef ONE_BYTE
`define ONE_BYTE 3'b001
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b010
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b100
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b01
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b10
`endif

module data_cache #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_LEN      = 32,
    parameter int BYTE_SIZE     = 8,
    parameter int LINE_WORD_NUM = 4,
    parameter int INDEX_WIDTH   = 4
) (
    input logic         clk,
    input logic         rst_n,
    data_cache_if.slave bus
);
    localparam int WORD_BITS = $clog2(LINE_WORD_NUM);
    localparam int OFF_BITS  = 2 + WORD_BITS;
    localparam int TAG_WIDTH = ADDR_WIDTH - OFF_BITS - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int NBYTES    = DATA_LEN / BYTE_SIZE;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_WAIT, REFILL_GAP, WRITE_WAIT, WRITE_GAP} state_t;

    state_t                 state, state_n;
    logic [WORD_BITS-1:0]   k, k_n;
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [2:0]             r_type;
    logic [DATA_LEN-1:0]    r_wdata;
    logic [LINES-1:0]       valid;
    logic [TAG_WIDTH-1:0]   tags [LINES];
    logic [DATA_LEN-1:0]    lines [LINES*LINE_WORD_NUM];
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic [WORD_BITS-1:0]   wsel;
    logic [1:0]             off;
    logic [DATA_LEN-1:0]    cur_word;
    logic                   hit, bad, store_hit, refill_cap, fill_done;
    logic                   ready_n, resp_valid_n, resp_error_n;
    logic [DATA_LEN-1:0]    rdata_n, wdata_n;
    logic [1:0]             sig_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [2:0]             dtype_n;

    function automatic int nbytes(input logic [2:0] t);
        return t == `FOUR_BYTE ? 4 : t == `TWO_BYTE ? 2 : 1;
    endfunction

    // Lines hold memory byte order: byte at offset p sits in w[DATA_LEN-1-p*BYTE_SIZE -: BYTE_SIZE].
    function automatic logic [DATA_LEN-1:0] to_core(input logic [DATA_LEN-1:0] w, input logic [1:0] o,
                                                    input logic [2:0] t);
        logic [DATA_LEN-1:0] r;
        logic [1:0]          p;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            p = o + 2'(i);
            if (i < nbytes(t)) r[i*BYTE_SIZE +: BYTE_SIZE] = w[DATA_LEN-1-int'(p)*BYTE_SIZE -: BYTE_SIZE];
        end
        return r;
    endfunction

    function automatic logic [DATA_LEN-1:0] to_mem(input logic [DATA_LEN-1:0] d, input logic [2:0] t);
        logic [DATA_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++)
            if (i < nbytes(t)) r[DATA_LEN-1-i*BYTE_SIZE -: BYTE_SIZE] = d[i*BYTE_SIZE +: BYTE_SIZE];
        return r;
    endfunction

    function automatic logic [DATA_LEN-1:0] merge(input logic [DATA_LEN-1:0] w, input logic [DATA_LEN-1:0] d,
                                                  input logic [1:0] o, input logic [2:0] t);
        logic [DATA_LEN-1:0] r;
        logic [1:0]          p;
        r = w;
        for (int i = 0; i < NBYTES; i++) begin
            p = o + 2'(i);
            if (i < nbytes(t)) r[DATA_LEN-1-int'(p)*BYTE_SIZE -: BYTE_SIZE] = d[i*BYTE_SIZE +: BYTE_SIZE];
        end
        return r;
    endfunction

    assign off        = r_addr[1:0];
    assign wsel       = r_addr[2 +: WORD_BITS];
    assign idx        = r_addr[OFF_BITS +: INDEX_WIDTH];
    assign tag        = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign cur_word   = lines[{idx, wsel}];
    assign hit        = valid[idx] && tags[idx] == tag;
    assign bad        = !(r_type == `ONE_BYTE || (r_type == `TWO_BYTE && !off[0]) ||
                          (r_type == `FOUR_BYTE && off == 2'b00));
    assign store_hit  = state == LOOKUP && !bad && r_write && hit;
    assign refill_cap = state == REFILL_WAIT && bus.mem_status == `MEM_DATA_FINISHED;
    assign fill_done  = state == REFILL_GAP && bus.mem_status == `MEM_RESTING && k == '1;

    // Next state and next values of every registered output.
    always_comb begin
        state_n      = state;
        k_n          = k;
        ready_n      = bus.req_ready;
        resp_valid_n = 1'b0;
        resp_error_n = 1'b0;
        rdata_n      = bus.resp_rdata;
        sig_n        = bus.d_cache_mem_vis_signal;
        addr_n       = bus.d_cache_mem_vis_addr;
        wdata_n      = bus.mem_written_data;
        dtype_n      = bus.mem_data_type;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_n = LOOKUP;
                ready_n = 1'b0;
            end
            LOOKUP: if (bad) begin
                resp_valid_n = 1'b1;
                resp_error_n = 1'b1;
                ready_n      = 1'b1;
                state_n      = IDLE;
            end else if (r_write) begin
                sig_n   = `MEM_WRITE;
                addr_n  = r_addr;
                wdata_n = to_mem(r_wdata, r_type);
                dtype_n = r_type;
                state_n = WRITE_WAIT;
            end else if (hit) begin
                resp_valid_n = 1'b1;
                rdata_n      = to_core(cur_word, off, r_type);
                ready_n      = 1'b1;
                state_n      = IDLE;
            end else begin
                k_n     = '0;
                sig_n   = `MEM_READ;
                addr_n  = {r_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
                state_n = REFILL_WAIT;
            end
            REFILL_WAIT: if (bus.mem_status == `MEM_DATA_FINISHED) begin
                sig_n   = `MEM_NOP;
                state_n = REFILL_GAP;
            end
            REFILL_GAP: if (bus.mem_status == `MEM_RESTING) begin
                if (k != '1) begin
                    k_n     = k + 1'b1;
                    sig_n   = `MEM_READ;
                    addr_n  = {r_addr[ADDR_WIDTH-1:OFF_BITS], k_n, 2'b00};
                    state_n = REFILL_WAIT;
                end else begin
                    resp_valid_n = 1'b1;
                    rdata_n      = to_core(cur_word, off, r_type);
                    ready_n      = 1'b1;
                    state_n      = IDLE;
                end
            end
            WRITE_WAIT: if (bus.mem_status == `MEM_DATA_FINISHED) begin
                sig_n   = `MEM_NOP;
                state_n = WRITE_GAP;
            end
            WRITE_GAP: if (bus.mem_status == `MEM_RESTING) begin
                resp_valid_n = 1'b1;
                ready_n      = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, valid bits and registered outputs; reset aborts any memory operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= IDLE;
            k                          <= '0;
            valid                      <= '0;
            bus.req_ready              <= 1'b1;
            bus.resp_valid             <= 1'b0;
            bus.resp_error             <= 1'b0;
            bus.resp_rdata             <= '0;
            bus.d_cache_mem_vis_signal <= `MEM_NOP;
            bus.d_cache_mem_vis_addr   <= '0;
            bus.mem_written_data       <= '0;
            bus.mem_data_type          <= '0;
        end else begin
            state                      <= state_n;
            k                          <= k_n;
            if (fill_done) valid[idx]  <= 1'b1;
            bus.req_ready              <= ready_n;
            bus.resp_valid             <= resp_valid_n;
            bus.resp_error             <= resp_error_n;
            bus.resp_rdata             <= rdata_n;
            bus.d_cache_mem_vis_signal <= sig_n;
            bus.d_cache_mem_vis_addr   <= addr_n;
            bus.mem_written_data       <= wdata_n;
            bus.mem_data_type          <= dtype_n;
        end
    end

    // Request latch, tag and data arrays; these need no reset since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_type  <= bus.req_data_type;
            r_wdata <= bus.req_wdata;
        end
        if (store_hit) lines[{idx, wsel}] <= merge(cur_word, r_wdata, off, r_type);
        if (refill_cap) lines[{idx, k}] <= bus.mem_data;
        if (fill_done) tags[idx] <= tag;
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a small memory responder
`ifndef ONE_BYTE
`define ONE_BYTE 3'b001
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b010
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b100
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b01
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b10
`endif

module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          n_checks = 0;
    int          n_fails = 0;
    int          nops = 0;
    int          edges;
    logic [7:0]  mem [0:131071];
    logic [31:0] op_sig[$], op_addr[$], op_data[$], op_type[$];
    logic [31:0] rd;
    logic        err;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [1:0]  prev_sig = `MEM_NOP;
    logic [16:0] ma;

    data_cache_if #(.ADDR_WIDTH(17), .DATA_LEN(32)) bus ();
    data_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int nb(input logic [2:0] t);
        return t == `FOUR_BYTE ? 4 : t == `TWO_BYTE ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_sig"}, 32'(bus.d_cache_mem_vis_signal), 32'(`MEM_NOP));
        chk({tag, "_addr"}, 32'(bus.d_cache_mem_vis_addr), 32'd0);
        chk({tag, "_wdata"}, bus.mem_written_data, 32'd0);
        chk({tag, "_dtype"}, 32'(bus.mem_data_type), 32'd0);
    endtask

    task automatic clear_log();
        op_sig.delete();
        op_addr.delete();
        op_data.delete();
        op_type.delete();
        nops = 0;
    endtask

    task automatic req(input logic w, input logic [16:0] a, input logic [2:0] t, input logic [31:0] d);
        clear_log();
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_write     = w;
        bus.req_addr      = a;
        bus.req_data_type = t;
        bus.req_wdata     = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("ready_drop", 32'(bus.req_ready), 32'd0);
        edges = 1;
        while (!bus.resp_valid && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("resp_seen", 32'(bus.resp_valid), 32'd1);
        rd  = bus.resp_rdata;
        err = bus.resp_error;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        chk("ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic chk_refill(input string tag, input logic [16:0] base);
        chk({tag, "_ops"}, 32'(op_sig.size()), 32'd4);
        chk({tag, "_nops"}, 32'(nops), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_sig"}, op_sig[i], 32'(`MEM_READ));
            chk({tag, "_addr"}, op_addr[i], 32'(base) + 32'(4 * i));
        end
    endtask

    // Memory responder: two idle cycles per access, FINISHED held until the cache drops to NOP.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy           = 1'b0;
                bus.mem_status = `MEM_RESTING;
            end else if (bus.mem_status == `MEM_RESTING && bus.d_cache_mem_vis_signal != `MEM_NOP && !busy) begin
                busy = 1'b1;
                cnt  = 1;
                op_sig.push_back(32'(bus.d_cache_mem_vis_signal));
                op_addr.push_back(32'(bus.d_cache_mem_vis_addr));
                op_data.push_back(bus.mem_written_data);
                op_type.push_back(32'(bus.mem_data_type));
            end else if (busy && bus.mem_status == `MEM_RESTING) begin
                if (cnt > 0) cnt--;
                else begin
                    ma = bus.d_cache_mem_vis_addr;
                    if (bus.d_cache_mem_vis_signal == `MEM_READ)
                        bus.mem_data = {mem[ma], mem[ma + 17'd1], mem[ma + 17'd2], mem[ma + 17'd3]};
                    else
                        for (int i = 0; i < nb(bus.mem_data_type); i++)
                            mem[ma + 17'(i)] = bus.mem_written_data[31 - 8 * i -: 8];
                    bus.mem_status = `MEM_DATA_FINISHED;
                end
            end else if (bus.mem_status == `MEM_DATA_FINISHED && bus.d_cache_mem_vis_signal == `MEM_NOP) begin
                bus.mem_status = `MEM_RESTING;
                busy           = 1'b0;
            end
            if (prev_sig != `MEM_NOP && bus.d_cache_mem_vis_signal == `MEM_NOP) nops++;
            prev_sig = bus.d_cache_mem_vis_signal;
        end
    end

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_addr      = '0;
        bus.req_data_type = `FOUR_BYTE;
        bus.req_wdata     = '0;
        bus.mem_data      = '0;
        bus.mem_status    = `MEM_RESTING;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[16] = 8'h11;
        mem[17] = 8'h22;
        mem[18] = 8'h33;
        mem[19] = 8'h44;
        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold word load refills the whole line
        req(1'b0, 17'h10, `FOUR_BYTE, 32'h0);
        chk_refill("cold", 17'h10);
        chk("cold_rdata", rd, 32'h44332211);
        chk("cold_err", 32'(err), 32'd0);

        // Byte hit, no traffic, response on the second edge
        req(1'b0, 17'h13, `ONE_BYTE, 32'h0);
        chk("hit_ops", 32'(op_sig.size()), 32'd0);
        chk("hit_edges", 32'(edges), 32'd2);
        chk("hit_rdata", rd, 32'h00000044);

        // Half-word store hit is written through and updates the line
        req(1'b1, 17'h12, `TWO_BYTE, 32'hBEEF);
        chk("st_ops", 32'(op_sig.size()), 32'd1);
        chk("st_sig", op_sig[0], 32'(`MEM_WRITE));
        chk("st_addr", op_addr[0], 32'h12);
        chk("st_data", op_data[0], 32'hEFBE0000);
        chk("st_type", op_type[0], 32'(`TWO_BYTE));
        chk("st_err", 32'(err), 32'd0);
        req(1'b0, 17'h10, `FOUR_BYTE, 32'h0);
        chk("sthit_ops", 32'(op_sig.size()), 32'd0);
        chk("sthit_rdata", rd, 32'hBEEF2211);
        req(1'b0, 17'h12, `TWO_BYTE, 32'h0);
        chk("half_rdata", rd, 32'h0000BEEF);

        // Store miss does not allocate
        req(1'b1, 17'h400, `FOUR_BYTE, 32'hCAFEF00D);
        chk("stm_ops", 32'(op_sig.size()), 32'd1);
        chk("stm_data", op_data[0], 32'h0DF0FECA);
        chk("stm_type", op_type[0], 32'(`FOUR_BYTE));
        req(1'b0, 17'h400, `FOUR_BYTE, 32'h0);
        chk_refill("stm_load", 17'h400);
        chk("stm_rdata", rd, 32'hCAFEF00D);

        // Misaligned and unknown-width requests
        req(1'b0, 17'h11, `FOUR_BYTE, 32'h0);
        chk("mis_w_err", 32'(err), 32'd1);
        chk("mis_w_ops", 32'(op_sig.size()), 32'd0);
        chk("mis_w_nops", 32'(nops), 32'd0);
        req(1'b0, 17'h13, `TWO_BYTE, 32'h0);
        chk("mis_h_err", 32'(err), 32'd1);
        req(1'b0, 17'h10, 3'b011, 32'h0);
        chk("bad_type_err", 32'(err), 32'd1);
        req(1'b1, 17'h12, `FOUR_BYTE, 32'h12345678);
        chk("mis_st_err", 32'(err), 32'd1);
        chk("mis_st_ops", 32'(op_sig.size()), 32'd0);
        req(1'b0, 17'h11, `ONE_BYTE, 32'h0);
        chk("byte_err", 32'(err), 32'd0);
        chk("byte_rdata", rd, 32'h00000022);

        // Conflicting tag evicts the line; reload sees written-through memory
        req(1'b0, 17'h410, `FOUR_BYTE, 32'h0);
        chk_refill("conf", 17'h410);
        chk("conf_rdata", rd, 32'h0);
        req(1'b0, 17'h10, `FOUR_BYTE, 32'h0);
        chk_refill("reload", 17'h10);
        chk("reload_rdata", rd, 32'hBEEF2211);

        // Reset during the second refill read
        clear_log();
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_write     = 1'b0;
        bus.req_addr      = 17'h30;
        bus.req_data_type = `FOUR_BYTE;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        edges = 0;
        while (op_sig.size() < 2 && edges < 100) begin
            @(posedge clk);
            #2;
            edges++;
        end
        chk("rst_second_read", 32'(op_sig.size()), 32'd2);
        rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(posedge clk);
        #1 chk_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        req(1'b0, 17'h10, `FOUR_BYTE, 32'h0);
        chk_refill("post_rst", 17'h10);
        chk("post_rst_rdata", rd, 32'hBEEF2211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
